// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO used as the standard buffering element between
// datapath stages. It provides an occupancy count, programmable almost-full and
// almost-empty flags, and sticky overflow/underflow error flags. The read side
// has two modes. In registered mode there is one cycle of latency and rvalid
// pulses. In first-word-fall-through mode the head word is always shown on rdata.
//
// Parameters:
//   DATA_W     data word width in bits (>= 1)
//   DEPTH      number of entries, power of two, >= 4
//   AF_THRESH  almost_full  when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//   FWFT       0 = registered read, 1 = first-word-fall-through
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous reset, active low
//   wr_en, wdata  write request and data
//   rd_en         read request (FWFT: pop the current head)
//   rdata         read data
//   rvalid        registered mode: one-cycle valid pulse; FWFT: !empty
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow      sticky, write attempted while full
//   underflow     sticky, read attempted while empty
//   clr_err       synchronous clear of overflow/underflow
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_W must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit, so a plain subtraction gives 0..DEPTH.
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          wr_accept;
  logic          rd_accept;

  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

  // Status comes only from the registered pointers. It never looks at the
  // wr_en/rd_en inputs of the same cycle.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A request is rejected at the full or empty boundary. Reset also blocks it,
  // so a write that arrives during reset does not change the memory.
  assign wr_accept = rst && wr_en && !full;
  assign rd_accept = rst && rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;

    // Clear first. If a new error happens in the same cycle, it sets the
    // flag again.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full)  overflow_d  = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Memory contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_addr] <= wdata;
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  if (FWFT) begin : g_fwft
    // The head word is always on rdata. The word written at one edge appears
    // on rdata after that edge.
    assign rdata  = mem[rd_addr];
    assign rvalid = !empty;
  end else begin : g_reg
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_accept;
        // rdata keeps its last value between reads.
        if (rd_accept) rdata_q <= mem[rd_addr];
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Directed testbench for sync_fifo_param with the default 8-bit x 16 geometry.
// u_reg uses registered-read mode and u_fwft uses first-word-fall-through.
// Both instances share the clock and reset.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;

  // Registered-read instance
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  // FWFT instance
  logic       f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_wdata;
  logic [7:0] f_rdata;
  logic       f_rvalid, f_full, f_empty, f_almost_full, f_almost_empty;
  logic       f_overflow, f_underflow;
  logic [4:0] f_count;

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wdata(f_wdata), .rd_en(f_rd_en),
    .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for a rising edge, then 1 time unit, before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got=%b exp=0", almost_full); end
    n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
    n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    n_tests++; if (f_empty !== 1'b1 || f_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_fwft got=%b%b exp=10", f_empty, f_rvalid); end
    $display("[TB] reset done");
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1;
      wdata = 8'(i);
      tick();
      $display("[TB] wr %02h count=%0d af=%b full=%b", wdata, count, almost_full, full);
      n_tests++; if (count !== 5'(i)) begin n_fail++; $display("FAIL fill_count got=%0d exp=%0d", count, i); end
      n_tests++; if (almost_full !== (i >= 14)) begin n_fail++; $display("FAIL fill_af at %0d got=%b exp=%b", i, almost_full, (i >= 14)); end
      n_tests++; if (almost_empty !== (i <= 2)) begin n_fail++; $display("FAIL fill_ae at %0d got=%b exp=%b", i, almost_empty, (i <= 2)); end
      n_tests++; if (full !== (i == 16)) begin n_fail++; $display("FAIL fill_full at %0d got=%b exp=%b", i, full, (i == 16)); end
    end
    // A write into the full FIFO must be rejected.
    wdata = 8'hFF;
    tick();
    wr_en = 1'b0;
    $display("[TB] wr FF (while full) count=%0d overflow=%b", count, overflow);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
    n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_ovf_count got=%0d exp=16", count); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      $display("[TB] rd %02h rvalid=%b count=%0d", rdata, rvalid, count);
      n_tests++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL drain_rvalid got=%b exp=1", rvalid); end
      n_tests++; if (rdata !== 8'(i)) begin n_fail++; $display("FAIL drain_rdata got=%h exp=%h", rdata, 8'(i)); end
      n_tests++; if (count !== 5'(16 - i)) begin n_fail++; $display("FAIL drain_count got=%0d exp=%0d", count, 16 - i); end
      tick();
      n_tests++; if (rvalid !== 1'b0 || rdata !== 8'(i)) begin n_fail++; $display("FAIL drain_hold got=%b/%h exp=0/%h", rvalid, rdata, 8'(i)); end
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", empty); end
    // A 17th read is an underflow. Overflow must still be set.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    $display("[TB] rd (while empty) underflow=%b", underflow);
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL drain_underflow got=%b exp=1", underflow); end
    n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL drain_uf_rvalid got=%b exp=0", rvalid); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL drain_uf_count got=%0d exp=0", count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sticky_overflow got=%b exp=1", overflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL clr_err got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1;
      wdata = 8'(8'h20 + k);
      tick();
    end
    wr_en = 1'b0;
    n_tests++; if (count !== 5'd5) begin n_fail++; $display("FAIL b2b_prefill got=%0d exp=5", count); end
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      wdata = 8'(8'h25 + k);
      tick();
      $display("[TB] wr %02h rd %02h count=%0d", wdata, rdata, count);
      n_tests++; if (count !== 5'd5) begin n_fail++; $display("FAIL b2b_count got=%0d exp=5", count); end
      n_tests++; if (rvalid !== 1'b1 || rdata !== 8'(8'h20 + k)) begin n_fail++; $display("FAIL b2b_rdata got=%b/%h exp=1/%h", rvalid, rdata, 8'(8'h20 + k)); end
    end
    wr_en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      $display("[TB] rd %02h count=%0d", rdata, count);
      n_tests++; if (rdata !== 8'(8'h48 + j)) begin n_fail++; $display("FAIL b2b_drain got=%h exp=%h", rdata, 8'(8'h48 + j)); end
    end
    rd_en = 1'b0;
    n_tests++; if (empty !== 1'b1 || underflow !== 1'b0) begin n_fail++; $display("FAIL b2b_end got=%b%b exp=10", empty, underflow); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wdata = 8'(8'h50 + i);
      tick();
    end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fs_full got=%b exp=1", full); end
    // When full, a simultaneous read is accepted and the write is rejected.
    rd_en = 1'b1;
    wdata = 8'h99;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    $display("[TB] wr 99 + rd %02h (while full) count=%0d overflow=%b", rdata, count, overflow);
    n_tests++; if (count !== 5'd15) begin n_fail++; $display("FAIL fs_count got=%0d exp=15", count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fs_overflow got=%b exp=1", overflow); end
    n_tests++; if (rvalid !== 1'b1 || rdata !== 8'h50) begin n_fail++; $display("FAIL fs_head got=%b/%h exp=1/50", rvalid, rdata); end
    // Refill to full, then set and clear overflow in the same cycle. Set must win.
    wr_en = 1'b1;
    wdata = 8'hA0;
    tick();
    wdata = 8'hEE;
    clr_err = 1'b1;
    tick();
    wr_en = 1'b0;
    clr_err = 1'b0;
    n_tests++; if (overflow !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL set_wins got=%b/%0d exp=1/16", overflow, count); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fs_clr got=%b exp=0", overflow); end
    // The rejected words 99 and EE must not appear in the FIFO.
    for (int j = 0; j < 16; j++) begin
      rd_en = 1'b1;
      tick();
      $display("[TB] rd %02h count=%0d", rdata, count);
      n_tests++; if (rdata !== ((j < 15) ? 8'(8'h51 + j) : 8'hA0)) begin n_fail++; $display("FAIL fs_order got=%h exp=%h", rdata, (j < 15) ? 8'(8'h51 + j) : 8'hA0); end
    end
    rd_en = 1'b0;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fs_empty got=%b exp=1", empty); end
  endtask

  task automatic test_fwft();
    f_wr_en = 1'b1;
    f_wdata = 8'hAA;
    tick();
    f_wr_en = 1'b0;
    $display("[TB] fwft wr AA rdata=%02h rvalid=%b", f_rdata, f_rvalid);
    n_tests++; if (f_rvalid !== 1'b1 || f_rdata !== 8'hAA) begin n_fail++; $display("FAIL fwft_show got=%b/%h exp=1/aa", f_rvalid, f_rdata); end
    n_tests++; if (f_count !== 5'd1) begin n_fail++; $display("FAIL fwft_count got=%0d exp=1", f_count); end
    f_wr_en = 1'b1;
    f_wdata = 8'hBB;
    tick();
    f_wr_en = 1'b0;
    tick();
    n_tests++; if (f_rdata !== 8'hAA || f_count !== 5'd2) begin n_fail++; $display("FAIL fwft_hold got=%h/%0d exp=aa/2", f_rdata, f_count); end
    f_rd_en = 1'b1;
    tick();
    $display("[TB] fwft pop rdata=%02h count=%0d", f_rdata, f_count);
    n_tests++; if (f_rdata !== 8'hBB || f_count !== 5'd1) begin n_fail++; $display("FAIL fwft_pop1 got=%h/%0d exp=bb/1", f_rdata, f_count); end
    tick();
    f_rd_en = 1'b0;
    $display("[TB] fwft pop count=%0d empty=%b", f_count, f_empty);
    n_tests++; if (f_empty !== 1'b1 || f_rvalid !== 1'b0) begin n_fail++; $display("FAIL fwft_pop2 got=%b%b exp=10", f_empty, f_rvalid); end
  endtask

  task automatic test_mid_reset();
    // Create an underflow first, so the reset has a flag to clear.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL mr_pre_uf got=%b exp=1", underflow); end
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1;
      wdata = 8'(8'h60 + i);
      tick();
    end
    n_tests++; if (count !== 5'd9) begin n_fail++; $display("FAIL mr_count9 got=%0d exp=9", count); end
    // Assert reset while the burst keeps requesting.
    rst = 1'b0;
    rd_en = 1'b1;
    tick();
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    $display("[TB] mid-burst reset count=%0d empty=%b", count, empty);
    n_tests++; if (count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL mr_count got=%0d/%b exp=0/1", count, empty); end
    n_tests++; if (underflow !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mr_err got=%b%b exp=00", overflow, underflow); end
    n_tests++; if (rvalid !== 1'b0 || rdata !== 8'h00) begin n_fail++; $display("FAIL mr_rdata got=%b/%h exp=0/00", rvalid, rdata); end
    n_tests++; if (almost_empty !== 1'b1 || almost_full !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL mr_flags got=%b%b%b exp=100", almost_empty, almost_full, full); end
    // When empty, a simultaneous write is accepted and the read is rejected.
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'h77;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_tests++; if (count !== 5'd1 || underflow !== 1'b1 || rvalid !== 1'b0) begin n_fail++; $display("FAIL mr_empty_wr_rd got=%0d/%b/%b exp=1/1/0", count, underflow, rvalid); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    $display("[TB] rd %02h after reset", rdata);
    n_tests++; if (rvalid !== 1'b1 || rdata !== 8'h77 || empty !== 1'b1) begin n_fail++; $display("FAIL mr_newdata got=%b/%h/%b exp=1/77/1", rvalid, rdata, empty); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wdata = '0;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_wdata = '0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_simul();
    test_fwft();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, single clock domain. Generalises the team's 8-bit x 16 sync FIFO to configurable width and depth. Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable read mode: registered read or first-word-fall-through (FWFT). Used as the standard buffering element between datapath stages.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
wr_en  in  1  write request
wdata  in  DATA_W  write data
rd_en  in  1  read request (FWFT=1: pop current head)
rdata  out  DATA_W  read data
rvalid  out  1  FWFT=0: rdata valid pulse; FWFT=1: equals !empty
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Pointers wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits; low bits address memory, MSB is the wrap bit. count = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)).
- All flags derive combinationally from registered pointers only; they never depend on same-cycle wr_en/rd_en.
- Write accepted iff wr_en && !full: mem[wr_ptr] <= wdata, wr_ptr++ (free wrap).
- Read accepted iff rd_en && !empty: rd_ptr++.
- Simultaneous accepted write and read: count unchanged; both pointers advance.
- At full with wr_en && rd_en: read accepted, write rejected, overflow set; count becomes DEPTH-1.
- At empty with wr_en && rd_en: write accepted, read rejected, underflow set; count becomes 1.
- Rejected operations never modify memory or pointers.
- overflow/underflow: set on a rejected request, held until clr_err=1 or reset. If set and clr_err occur together, set wins.
- FWFT=0: on accepted read, rdata <= mem[rd_ptr] at that edge; rvalid=1 for exactly that following cycle. rdata holds its last value otherwise; it is never driven to Z.
- FWFT=1: rdata = mem[rd_ptr] combinationally. A word written into an empty FIFO is visible on rdata, with rvalid=1, the cycle after the write edge. rd_en pops the head.
- Reset (rst=0 at an edge): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0, rvalid=0, registered rdata=0. Memory contents are not reset. Reset overrides all concurrent requests, including mid-stream.
- Elaboration-time checks: DEPTH must be a power of two; thresholds must be in range.

Test Plan:
1. Reset, write 0x01..0x10 (DEPTH=16) -> count=16, full=1; almost_full rises at count=14; a further write sets overflow and leaves mem/count unchanged.
2. Drain 16 reads with FWFT=0 -> rdata 0x01..0x10 in order, each one cycle after rd_en with rvalid=1; empty=1 after the last; a 17th read sets underflow.
3. Continuous simultaneous wr/rd for 40 cycles starting at count=5 -> count stays 5; pointers wrap past 16 twice; data order preserved.
4. Full FIFO with wr_en=rd_en=1 -> count=15, overflow=1, head popped; a later clr_err=1 clears overflow.
5. FWFT=1: write 0xAA into empty -> next cycle rdata=0xAA, rvalid=1, without rd_en; rd_en pops -> empty=1.
6. Assert rst=0 mid-burst at count=9 -> next cycle count=0, empty=1, flags cleared; subsequent write/read returns the new data only.
